// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction buffer between fetch and dispatch.
// Fetch pushes up to N contiguous lanes per cycle; dispatch pops up to N of
// the oldest entries per cycle. Occupancy is tracked with an explicit count,
// so full and empty are never ambiguous.
// Packet layout: bit INST_W is the valid flag, bits INST_W-1:0 the payload.
// Optional feature macro: INST_BUFFER_DEBUG_EN exposes the head, tail and
// count registers on debug_* output ports.

`ifndef N
`define N 3
`endif

module inst_buffer #(
  parameter int N      = `N,
  parameter int DEPTH  = 16,
  parameter int INST_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N-1:0][INST_W:0]       in_insts,
  input  logic [$clog2(N+1)-1:0]       num_in,
  input  logic [$clog2(N+1)-1:0]       num_dispatch,
  input  logic                         flush,
  output logic [$clog2(N+1)-1:0]       buf_open,
  output logic [N-1:0][INST_W:0]       out_insts
`ifdef INST_BUFFER_DEBUG_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   debug_count,
  output logic [$clog2(DEPTH)-1:0]     debug_head,
  output logic [$clog2(DEPTH)-1:0]     debug_tail
`endif
);

  localparam int LW = $clog2(N + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [INST_W:0] mem [DEPTH];

  logic [PW-1:0] head, head_next;
  logic [PW-1:0] tail, tail_next;
  logic [CW-1:0] count, count_next;

  logic [CW-1:0] free_slots;
  logic [CW-1:0] open_slots;
  logic [CW-1:0] num_in_w;
  logic [CW-1:0] num_disp_w;
  logic [CW-1:0] push;
  logic [CW-1:0] pop;

  // Free-slot credit from registered count only, then clamp push and pop.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    open_slots = free_slots;
    if (free_slots > CW'(N)) begin
      open_slots = CW'(N);
    end
    buf_open = LW'(open_slots);

    num_in_w   = CW'(num_in);
    num_disp_w = CW'(num_dispatch);

    push = num_in_w;
    if (open_slots < num_in_w) begin
      push = open_slots;
    end

    pop = num_disp_w;
    if (count < pop) begin
      pop = count;
    end
    if (CW'(N) < pop) begin
      pop = CW'(N);
    end
  end

  // Next pointer and occupancy values; flush overrides any push or pop.
  always_comb begin
    head_next  = head + PW'(pop);
    tail_next  = tail + PW'(push);
    count_next = count + push - pop;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  // Pointer and count registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage; accepted lanes land at consecutive slots from tail, wrapping.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset && !flush && (CW'(i) < push)) begin
        mem[tail + PW'(i)] <= in_insts[i];
      end
    end
  end

  // Present the oldest entries in program order, masking lanes beyond count.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_insts[i] = mem[head + PW'(i)];
      if (CW'(i) >= count) begin
        out_insts[i][INST_W] = 1'b0;
      end
    end
  end

`ifdef INST_BUFFER_DEBUG_EN
  assign debug_count = count;
  assign debug_head  = head;
  assign debug_tail  = tail;
`endif

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter N, default `N; superscalar width, equal to the dispatch width.
REQ-002 Parameter DEPTH, default 16; entry count, power of two, SHALL be >= 2*N.
REQ-003 clock  input  1  single system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low; buffer is in reset while reset==0.
REQ-005 in_insts  input  INST_PACKET[N-1:0]  fetched group from fetch; lane 0 is oldest.
REQ-006 num_in  input  $clog2(N+1)  count of valid fetched lanes, contiguous from lane 0.
REQ-007 num_dispatch  input  $clog2(N+1)  count of entries accepted by dispatch this cycle.
REQ-008 flush  input  1  squash all buffered instructions (mispredict/exception).
REQ-009 buf_open  output  $clog2(N+1)  free slots, min(DEPTH-count, N); fetch SHALL NOT push more.
REQ-010 out_insts  output  INST_PACKET[N-1:0]  oldest min(count,N) entries to dispatch; lane 0 is oldest.

Function
REQ-011 Storage is a circular FIFO with head (oldest), tail (next write) and count registers; pointers advance modulo DEPTH.
REQ-012 out_insts[i] = entry[(head+i) mod DEPTH] for i < count; .valid forced 0 for i >= count; driven from registered state only (no in_insts to out_insts path).
REQ-013 buf_open is computed from registered count only; same-cycle pops are not credited.
REQ-014 Effective push = min(num_in, buf_open); lanes 0..push-1 are written at tail..tail+push-1; excess lanes are dropped.
REQ-015 Effective pop = min(num_dispatch, count, N); head advances by pop.
REQ-016 Simultaneous push and pop: count_next = count + push - pop; a pushed entry is first visible on out_insts the cycle after the write (write-to-dispatch latency 1).
REQ-017 count never exceeds DEPTH and never underflows; there is no full/empty ambiguity (count is explicit).
REQ-018 Full (count==DEPTH): buf_open=0, all pushes dropped, pops proceed normally.
REQ-019 Empty (count==0): all out_insts valid=0, pops ignored.
REQ-020 flush=1: next cycle head=tail=count=0; push and pop in the same cycle are ignored; flush takes priority over both.
REQ-021 Wrap-around: a push or pop group straddling index DEPTH-1 -> 0 SHALL keep program order.
REQ-022 Entry contents are not cleared on pop or flush; only count determines validity.

Reset
REQ-023 While reset==0: head=0, tail=0, count=0, out_insts all valid=0, buf_open=N (asynchronous, immediate).
REQ-024 Deassertion mid-stream discards all prior contents; the first push is accepted on the first posedge with reset==1.

Configuration
REQ-025 Macro INST_BUFFER_DEBUG_EN: when defined, adds outputs debug_count ($clog2(DEPTH+1)), debug_head and debug_tail ($clog2(DEPTH)), each equal to the registered value.
REQ-026 When INST_BUFFER_DEBUG_EN is not defined, these ports do not exist and functional behaviour is identical.

Verification (N=3, DEPTH=8)
REQ-027 Reset -> count=0, buf_open=3, out valid=000; push 3 (A,B,C), pop 0 -> next cycle out=A,B,C valid=111, count=3.
REQ-028 count=7, num_in=3 -> buf_open=1; only lane 0 written, count=8, buf_open=0 next cycle; further push with num_in=3 -> count remains 8.
REQ-029 head=6, count=2, push 3, pop 2 -> tail wraps 0->3, head=0, count=3, out = three new entries in order.
REQ-030 count=2, num_dispatch=3 -> pop clamped to 2, count=0, out valid=000; with simultaneous push 2 -> count=2.
REQ-031 count=5, flush=1 with num_in=3 and num_dispatch=2 -> next cycle count=0, head=tail=0, buf_open=3, out valid=000.
REQ-032 reset asserted asynchronously mid-cycle with count=4 -> outputs go to reset values before the next clock edge.
